// File: rtl/exp_lut_arb.sv
// ============================================================================
//  Module      : exp_lut_arb
//  Description : Round-robin arbiter sharing one combinational exp_lut among
//                NREQ requesters through a two-stage valid/ready pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_lut_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int CW   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DW-1:0]            lut_in,
    input  logic [DW-1:0]            lut_out,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DW-1:0]            resp_data,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [CW-1:0]            done_cnt
);

    localparam int             IDW    = $clog2(NREQ);
    localparam logic [IDW:0]   c_nreq = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);

    logic [DW-1:0]  r_lut_in;
    logic [IDW-1:0] r_s0_id;
    logic           r_s0_valid;
    logic [DW-1:0]  r_resp_data;
    logic [IDW-1:0] r_resp_id;
    logic           r_resp_valid;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_done_cnt;

    logic           w_adv1;
    logic           w_ld0;
    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW:0]   w_sum;
    logic           w_grant;
    logic [NREQ-1:0] w_req_ready;
    logic [IDW-1:0] w_next_ptr;
    logic [DW-1:0]  w_sel_data;

    assign w_adv1 = r_s0_valid && (!r_resp_valid || resp_ready);
    assign w_ld0  = !r_s0_valid || w_adv1;

    // Scan requesters starting at the pointer; the sum never exceeds 2*NREQ-2,
    // so one conditional subtraction is enough for the modulo.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    // Reset gates the grant so no requester sees ready while rst_n is low.
    assign w_grant = w_found && w_ld0 && rst_n;

    always_comb begin
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

    assign w_next_ptr = (w_winner == c_last) ? '0 : w_winner + IDW'(1);
    assign w_sel_data = req_data[w_winner*DW +: DW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lut_in     <= '0;
            r_s0_id      <= '0;
            r_s0_valid   <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_valid <= 1'b0;
            r_ptr        <= '0;
            r_done_cnt   <= '0;
        end else begin
            if (w_ld0) begin
                if (w_grant) begin
                    r_lut_in   <= w_sel_data;
                    r_s0_id    <= w_winner;
                    r_s0_valid <= 1'b1;
                    r_ptr      <= w_next_ptr;
                end else begin
                    r_s0_valid <= 1'b0;
                end
            end
            if (w_adv1) begin
                r_resp_data  <= lut_out;
                r_resp_id    <= r_s0_id;
                r_resp_valid <= 1'b1;
            end else if (r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
            if (r_resp_valid && resp_ready) begin
                r_done_cnt <= r_done_cnt + CW'(1);
            end
        end
    end

    assign req_ready  = w_req_ready;
    assign lut_in     = r_lut_in;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign done_cnt   = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exp_lut_arb.sv
// ============================================================================
//  Module      : tb_exp_lut_arb
//  Description : Scoreboard bench for exp_lut_arb with a stand-in exp_lut.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exp_lut_arb;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [DW-1:0]     lut_in;
    logic [DW-1:0]     lut_out;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_data;
    logic [IDW-1:0]    resp_id;
    logic [CW-1:0]     done_cnt;

    int n_vec = 0;
    int n_err = 0;

    exp_lut_arb #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .lut_in     (lut_in),
        .lut_out    (lut_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in exp_lut: half-word swap then XOR with a fixed mask.
    function automatic logic [31:0] golden(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    assign lut_out = golden(lut_in);

    function automatic logic [31:0] mkdata(input int i, input int s);
        return {4'(i), 4'h3, 24'(s * 7919 + 13)};
    endfunction

    function automatic int enc(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    logic [IDW-1:0]  q_id[$];
    logic [DW-1:0]   q_data[$];
    logic [NREQ-1:0] acc_vec = '0;
    logic [CW-1:0]   mcnt = '0;
    int              mptr = 0;
    bit              in_rst = 1'b0;

    always @(negedge clk) begin
        int w;
        int ew;
        acc_vec = req_valid & req_ready;
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            if (in_rst) begin
                chk("rst_resp_valid", 64'(resp_valid), 64'd0);
                chk("rst_lut_in", 64'(lut_in), 64'd0);
                chk("rst_done_cnt", 64'(done_cnt), 64'd0);
            end
            q_id.delete();
            q_data.delete();
            mcnt   = '0;
            mptr   = 0;
            in_rst = 1'b1;
        end else begin
            in_rst = 1'b0;
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            chk("done_cnt", 64'(done_cnt), 64'(mcnt));
            if (resp_valid) begin
                if (q_id.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    chk("resp_id", 64'(resp_id), 64'(q_id[0]));
                    chk("resp_data", 64'(resp_data), 64'(q_data[0]));
                    if (resp_ready) begin
                        void'(q_id.pop_front());
                        void'(q_data.pop_front());
                    end
                end
            end
            if (resp_valid && resp_ready) mcnt = mcnt + CW'(1);
            if (acc_vec != '0) begin
                w  = enc(acc_vec);
                ew = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (ew < 0 && req_valid[(mptr + k) % NREQ]) ew = (mptr + k) % NREQ;
                end
                chk("rr_grant", 64'(w), 64'(ew));
                mptr = (w + 1) % NREQ;
                q_id.push_back(IDW'(w));
                q_data.push_back(golden(req_data[w*DW +: DW]));
            end
        end
    end

    int seq[NREQ];

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_vec[i]) begin
                seq[i]++;
                req_data[i*DW +: DW] = mkdata(i, seq[i]);
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n_acc;
        int nhs;
        int saw;
        int prev;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i] = 0;
            req_data[i*DW +: DW] = mkdata(i, 0);
        end

        // Single request from requester 2 with the 1.0f operand
        do_reset();
        req_valid  = 4'b0100;
        req_data[2*DW +: DW] = 32'h3F80_0000;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_resp_not_yet", 64'(resp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_resp_id", 64'(resp_id), 64'd2);
        chk("t1_resp_data", 64'(resp_data), 64'h5A5A_65DA);
        tick();
        @(negedge clk);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_resp_drop", 64'(resp_valid), 64'd0);

        // All requesting continuously: strict rotation, one result per cycle
        do_reset();
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_grant", 64'(enc(req_ready)), 64'(i % NREQ));
            if (i >= 2) chk("t2_resp_stream", 64'(resp_valid), 64'd1);
            tick();
        end

        // Backpressure: exactly two accepts fill the pipeline
        req_valid = '0;
        repeat (4) tick();
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) n_acc++;
            tick();
        end
        chk("t3_accepts", 64'(n_acc), 64'd2);
        @(negedge clk);
        chk("t3_ready_blocked", 64'(req_ready), 64'd0);
        chk("t3_resp_held", 64'(resp_valid), 64'd1);
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("t3_drained", 64'(q_id.size()), 64'd0);

        // Reset with both stages full, then requester 0 beats requester 3
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_resp_valid", 64'(resp_valid), 64'd0);
        chk("t4_lut_in", 64'(lut_in), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt), 64'd0);
        tick();
        rst_n      = 1'b1;
        req_valid  = 4'b1001;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_first_grant", 64'(req_ready), 64'h1);
        tick();
        @(negedge clk);
        chk("t4_second_grant", 64'(req_ready), 64'h8);

        // Completion counter wraps 15 -> 0 -> 1 over 17 handshakes
        do_reset();
        req_valid  = 4'b0010;
        resp_ready = 1'b1;
        nhs  = 0;
        saw  = 0;
        prev = 0;
        for (int c = 0; c < 40 && nhs < 17; c++) begin
            @(negedge clk);
            if (prev == 15) begin
                chk("t5_wrap", 64'(done_cnt), 64'd0);
                saw++;
            end
            prev = int'(done_cnt);
            if (resp_valid && resp_ready) nhs++;
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("t5_after17", 64'(done_cnt), 64'd1);
        chk("t5_saw_wrap", 64'(saw), 64'd1);

        // Mixed request and backpressure patterns against the scoreboard
        for (int c = 0; c < 150; c++) begin
            req_valid  = 4'($urandom);
            resp_ready = ($urandom % 4) != 0;
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t6_drained", 64'(q_id.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
